edge_detector: RTL and testbench

EDGE_DETECTOR -- requirements
Module: edge_detector

---
 rtl/edge_detector_sync.sv | 41 ++++
 rtl/edge_detector.sv | 78 +++++++
 tb/tb_edge_detector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/edge_detector_sync.sv
// Purpose: optional synchronizer chain ahead of the edge sampler.
//   STAGES = 0 : dout is din (plain wire, no flops).
//   STAGES > 0 : din passes through STAGES flops, all cleared by rst.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   din  - raw level input (may be asynchronous when STAGES >= 2)
//   dout - synchronized level
module edge_detector_sync #(
   parameter int unsigned STAGES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   if (STAGES == 0) begin : g_wire
      // Clock and reset are intentionally unused in the zero-stage build.
      logic unused_ok;
      assign unused_ok = ^{clk, rst};
      assign dout      = din;
   end else begin : g_chain
      logic [STAGES-1:0] sync_q;

      // Shift chain: stage 0 captures din, each later stage follows its predecessor.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q <= '0;
         end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
               sync_q[i] <= sync_q[i-1];
            end
         end
      end

      assign dout = sync_q[STAGES-1];
   end

endmodule

// File: rtl/edge_detector.sv
// Purpose: detect rising and falling transitions of a level signal and emit
//   one-clock-wide glitch-free pulses.
// Parameters:
//   SYNC_STAGES - extra synchronizer flops ahead of the sampler (0..4)
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   d      - monitored level
//   d_rise - one-cycle pulse per detected 0->1 transition
//   d_fall - one-cycle pulse per detected 1->0 transition
module edge_detector #(
   parameter int unsigned SYNC_STAGES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic d_rise,
   output logic d_fall
);

   // Counter reaches SYNC_STAGES+1 (at most 5), three bits suffice.
   localparam int unsigned FILL_W = 3;

   logic              sync_out;
   logic              s0_q,   s0_d;
   logic              prev_q, prev_d;
   logic              arm_q,  arm_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              track_c;

   edge_detector_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sync_out_src(d)),
      .dout (sync_out)
   );

   function automatic logic sync_out_src(input logic x);
      return x;
   endfunction

   // After reset the chain still holds zeros; until those have drained into s0
   // the history copies the sampler input so the level at release never looks
   // like an edge. With SYNC_STAGES = 0 this window is exactly the first edge.
   assign track_c = (fill_q <= FILL_W'(SYNC_STAGES));

   always_comb begin
      s0_d   = sync_out;
      prev_d = s0_q;
      arm_d  = 1'b1;
      fill_d = fill_q;
      if (track_c) begin
         prev_d = sync_out;
         fill_d = fill_q + FILL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_q   <= 1'b0;
         prev_q <= 1'b0;
         arm_q  <= 1'b0;
         fill_q <= '0;
      end else begin
         s0_q   <= s0_d;
         prev_q <= prev_d;
         arm_q  <= arm_d;
         fill_q <= fill_d;
      end
   end

   // Decoded only from flop outputs; s0 and prev cannot differ both ways at once.
   assign d_rise = arm_q & s0_q & ~prev_q;
   assign d_fall = arm_q & prev_q & ~s0_q;

endmodule

// File: tb/tb_edge_detector.sv
// Purpose: self-checking bench for edge_detector, SYNC_STAGES = 0 and 2
//   instances driven from the same d/rst, compared against a sample-history model.
module tb_edge_detector;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic d   = 1'b0;
   logic rise0, fall0, rise2, fall2;

   int total = 0;
   int bad   = 0;

   // Level of d seen at each rising edge since the last reset release.
   bit samp[$];

   edge_detector #(.SYNC_STAGES(0)) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .d      (d),
      .d_rise (rise0),
      .d_fall (fall0)
   );

   edge_detector #(.SYNC_STAGES(2)) u_dut2 (
      .clk    (clk),
      .rst    (rst),
      .d      (d),
      .d_rise (rise2),
      .d_fall (fall2)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // A transition is a change between two consecutive samples, seen lat cycles
   // late; nothing is reported until the first lat+1 samples after release are
   // history only.
   function automatic bit model_edge(input int lat, input bit want_rise);
      int n;
      bit cur, old;
      n = samp.size();
      if (n < lat + 2) return 1'b0;
      cur = samp[n-1-lat];
      old = samp[n-2-lat];
      return want_rise ? (cur && !old) : (old && !cur);
   endfunction

   always @(posedge rst) samp.delete();

   always @(posedge clk) begin
      if (!rst) samp.push_back(d);
      #1;
      check_bit("rise_s0", rise0, model_edge(0, 1'b1));
      check_bit("fall_s0", fall0, model_edge(0, 1'b0));
      check_bit("rise_s2", rise2, model_edge(2, 1'b1));
      check_bit("fall_s2", fall2, model_edge(2, 1'b0));
   end

   task automatic wait_until(input longint t);
      if (longint'($time) < t) #(t - longint'($time));
   endtask

   task automatic check_quiet(input string tag);
      check_bit({tag, "_rise_s0"}, rise0, 1'b0);
      check_bit({tag, "_fall_s0"}, fall0, 1'b0);
      check_bit({tag, "_rise_s2"}, rise2, 1'b0);
      check_bit({tag, "_fall_s2"}, fall2, 1'b0);
   endtask

   initial begin
      int r;
      bit v;

      // Reset with d low, then single rise / fall / repeat.
      wait_until(1);   rst = 1'b1;
      wait_until(12);  check_quiet("in_reset");
      wait_until(20);  rst = 1'b0;
      wait_until(40);  d = 1'b1;
      wait_until(46);  check_bit("rise_t46", rise0, 1'b1);
                       check_bit("nofall_t46", fall0, 1'b0);
      wait_until(50);  d = 1'b0;
      wait_until(53);  check_bit("rise_end_t53", rise0, 1'b1);
      wait_until(56);  check_bit("fall_t56", fall0, 1'b1);
                       check_bit("norise_t56", rise0, 1'b0);
      wait_until(66);  check_bit("rise_s2_t66", rise2, 1'b1);
                       check_bit("fall_s0_done_t66", fall0, 1'b0);
      wait_until(70);  d = 1'b1;
      wait_until(76);  check_bit("rise_t76", rise0, 1'b1);
                       check_bit("rise_s2_done_t76", rise2, 1'b0);
      wait_until(80);  d = 1'b0;
      wait_until(86);  check_bit("fall_t86", fall0, 1'b1);

      // Reset pulse while d is held high: no rise after release, one fall later.
      wait_until(142); d = 1'b1;
      wait_until(152); rst = 1'b1;
      #1 check_quiet("rst_dhigh");
      wait_until(172); rst = 1'b0;
      wait_until(202); d = 1'b0;
      wait_until(206); check_bit("fall_after_rst_t206", fall0, 1'b1);
      wait_until(216); check_bit("fall_once_t216", fall0, 1'b0);

      // Reset in the middle of a pulse cuts it off and it does not come back.
      wait_until(222); d = 1'b1;
      wait_until(226); check_bit("rise_pre_rst_t226", rise0, 1'b1);
      wait_until(228); rst = 1'b1;
      #1 check_bit("rise_cut_t229", rise0, 1'b0);
      wait_until(233); rst = 1'b0;
      wait_until(260);

      // Random levels, sub-cycle glitches that miss every edge, short resets.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         v = 1'($urandom);
         d = v;
         r = $urandom_range(0, 15);
         if (r == 0) begin
            #2 d = ~v;
            #3 d = v;
         end else if (r == 1) begin
            #1 rst = 1'b1;
            #1 check_quiet("rand_rst");
            #1 rst = 1'b0;
         end
      end

      #20;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
